// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding and default bus widths,
// matching the apb_master initiator.
package apb_pkg;

  localparam int APB_ADDR_WIDTH = 10;
  localparam int APB_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_slave_regfile.sv
// Register file for apb_slave: DEPTH x DATA_WIDTH words, async clear,
// one write port with optional byte strobes, combinational read port.
// Optional feature macro: APB_SLAVE_PSTRB_EN (adds wstrb_i byte enables).
module apb_slave_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int IDX_W      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we_i,
  input  logic [IDX_W-1:0]        waddr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
`ifdef APB_SLAVE_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
`endif
  input  logic [IDX_W-1:0]        raddr_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] bmask;

`ifdef APB_SLAVE_PSTRB_EN
  // Expand each strobe bit to a byte-wide lane mask
  always_comb begin
    bmask = '0;
    for (int b = 0; b < DATA_WIDTH/8; b++) bmask[b*8 +: 8] = {8{wstrb_i[b]}};
  end
`else
  assign bmask = '1;
`endif

  // Storage: async clear, masked word write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= (mem_q[waddr_i] & ~bmask) | (wdata_i & bmask);
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/apb_slave.sv
// APB completer: IDLE/SETUP/ACCESS FSM with fixed wait states, register
// file backing store, pslverr on addresses at or beyond DEPTH.
// Optional feature macro: APB_SLAVE_PSTRB_EN (adds pstrb byte strobes).
module apb_slave
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH  = APB_DATA_WIDTH,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic                    pselx,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [DATA_WIDTH-1:0]   pwdata,
`ifdef APB_SLAVE_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] pstrb,
`endif
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int         IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_Q = 4'(WAIT_CYCLES);

  apb_state_e            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
`ifdef APB_SLAVE_PSTRB_EN
  logic [DATA_WIDTH/8-1:0] strb_q, strb_d;
`endif

  logic                  in_range;
  logic                  we;
  logic [DATA_WIDTH-1:0] rdata;

  assign in_range = (32'(addr_q) < 32'(DEPTH));
  assign pready   = (state_q == APB_ACCESS) && (cnt_q == WAIT_Q);
  assign pslverr  = pready && !in_range;
  assign we       = pready && wr_q && in_range;
  assign prdata   = (pready && !wr_q && in_range) ? rdata : '0;

  // Next-state and SETUP-phase capture of address/control/data
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
`ifdef APB_SLAVE_PSTRB_EN
    strb_d  = strb_q;
`endif
    case (state_q)
      APB_IDLE: begin
        if (pselx && !penable) state_d = APB_SETUP;
      end
      APB_SETUP: begin
        addr_d  = paddr;
        wr_d    = pwrite;
        wdata_d = pwdata;
`ifdef APB_SLAVE_PSTRB_EN
        strb_d  = pstrb;
`endif
        cnt_d   = '0;
        if (!pselx)       state_d = APB_IDLE;
        else if (penable) state_d = APB_ACCESS;
      end
      APB_ACCESS: begin
        if (pready)                 state_d = (pselx && !penable) ? APB_SETUP : APB_IDLE;
        else if (!pselx || !penable) state_d = APB_IDLE;  // abandoned before completion
        else if (cnt_q < WAIT_Q)     cnt_d   = cnt_q + 4'd1;
      end
      default: state_d = APB_IDLE;
    endcase
  end

  // State, counter and latched transfer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= APB_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
`ifdef APB_SLAVE_PSTRB_EN
      strb_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
`ifdef APB_SLAVE_PSTRB_EN
      strb_q  <= strb_d;
`endif
    end
  end

  apb_slave_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .we_i    (we),
    .waddr_i (addr_q[IDX_W-1:0]),
    .wdata_i (wdata_q),
`ifdef APB_SLAVE_PSTRB_EN
    .wstrb_i (strb_q),
`endif
    .raddr_i (addr_q[IDX_W-1:0]),
    .rdata_o (rdata)
  );

endmodule

// File: tb/tb_apb_slave.sv
// Bench for apb_slave: two instances share one bus (WAIT_CYCLES=1 and 0),
// each checked against its own word-level memory model.
module tb_apb_slave;

`ifdef APB_SLAVE_PSTRB_EN
  localparam bit STRB = 1'b1;
`else
  localparam bit STRB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  paddr;
  logic        pselx, penable, pwrite;
  logic [31:0] pwdata;
`ifdef APB_SLAVE_PSTRB_EN
  logic [3:0]  pstrb;
`endif
  logic [31:0] prdata, prdata0;
  logic        pready, pready0, pslverr, pslverr0;

  always #5 clk = ~clk;

  apb_slave #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .DEPTH(16), .WAIT_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .paddr(paddr), .pselx(pselx), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata),
`ifdef APB_SLAVE_PSTRB_EN
    .pstrb(pstrb),
`endif
    .prdata(prdata), .pready(pready), .pslverr(pslverr));

  apb_slave #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .DEPTH(16), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .paddr(paddr), .pselx(pselx), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata),
`ifdef APB_SLAVE_PSTRB_EN
    .pstrb(pstrb),
`endif
    .prdata(prdata0), .pready(pready0), .pslverr(pslverr0));

  // word-level models: m1 for WAIT_CYCLES=1 instance, m0 for WAIT_CYCLES=0
  logic [31:0] m1 [16];
  logic [31:0] m0 [16];

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (!STRB || s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic clear_models();
    for (int i = 0; i < 16; i++) begin
      m0[i] = '0;
      m1[i] = '0;
    end
  endtask

  task automatic set_strb(input logic [3:0] s);
`ifdef APB_SLAVE_PSTRB_EN
    pstrb = s;
`else
    if (s == 4'hx) $display("unreachable");
`endif
  endtask

  // One full transfer; abort drops pselx after the first ACCESS cycle.
  // Returns the WAIT_CYCLES=1 instance's prdata/pslverr at its pready.
  task automatic xfer(input logic wr, input logic [9:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic ab,
                      output logic [31:0] rd, output logic er);
    logic        oob;
    logic [31:0] e1, e0;
    int          n;
    logic        done;
    oob = (a >= 10'd16);
    e1  = (!wr && !oob) ? m1[a[3:0]] : 32'h0;
    e0  = (!wr && !oob) ? m0[a[3:0]] : 32'h0;
    rd  = '0;
    er  = 1'b0;
    paddr = a; pwrite = wr; pwdata = d; set_strb(s); pselx = 1'b1; penable = 1'b0;
    step();
    chk("setup_rdy", 32'(pready), 0);
    chk("setup_rdy0", 32'(pready0), 0);
    penable = 1'b1;
    step();
    // bus contents during ACCESS must be ignored
    paddr = ~a; pwdata = ~d; set_strb(~s);
    chk("w0_rdy", 32'(pready0), 1);
    chk("w0_err", 32'(pslverr0), 32'(oob));
    chk("w0_rdata", prdata0, e0);
    if (wr && !oob) m0[a[3:0]] = merge(m0[a[3:0]], d, s);
    chk("w1_first_access_rdy", 32'(pready), 0);
    chk("w1_first_access_err", 32'(pslverr), 0);
    if (ab) begin
      pselx = 1'b0; penable = 1'b0;
      step();
      chk("abort_rdy", 32'(pready), 0);
      chk("abort_rdy0", 32'(pready0), 0);
      return;
    end
    n = 1; done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (pready) begin done = 1'b1; break; end
      n++;
    end
    chk("rdy_timeout", 32'(done), 1);
    chk("wait_states", n, 1);
    chk("w1_err", 32'(pslverr), 32'(oob));
    chk("w1_rdata", prdata, e1);
    chk("w0_after_done", 32'(pready0), 0);
    rd = prdata; er = pslverr;
    if (done && wr && !oob) m1[a[3:0]] = merge(m1[a[3:0]], d, s);
    pselx = 1'b0; penable = 1'b0;
    step();
    chk("idle_rdy", 32'(pready), 0);
    chk("idle_err", 32'(pslverr), 0);
  endtask

  typedef struct {
    logic        wr;
    logic [9:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    logic        ab;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] rd;
  logic        er;

  initial begin
    tbl.push_back('{1'b1, 10'd1,    32'hDEADBEEF, 4'hF, 1'b0, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 10'd1,    32'h0,        4'hF, 1'b0, 32'hDEADBEEF, 1'b0});
    tbl.push_back('{1'b1, 10'd16,   32'hFFFFFFFF, 4'hF, 1'b0, 32'h0,        1'b1});
    tbl.push_back('{1'b0, 10'd0,    32'h0,        4'hF, 1'b0, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 10'd16,   32'h0,        4'hF, 1'b0, 32'h0,        1'b1});
    tbl.push_back('{1'b1, 10'd3,    32'h0BADF00D, 4'hF, 1'b0, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 10'd3,    32'h0,        4'hF, 1'b0, 32'h0BADF00D, 1'b0});
    tbl.push_back('{1'b1, 10'd3,    32'hA5A5A5A5, 4'hF, 1'b1, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 10'd3,    32'h0,        4'hF, 1'b0, 32'h0BADF00D, 1'b0});
    tbl.push_back('{1'b1, 10'd15,   32'h00000005, 4'hF, 1'b0, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 10'd15,   32'h0,        4'hF, 1'b0, 32'h00000005, 1'b0});
    tbl.push_back('{1'b1, 10'd1023, 32'h12121212, 4'hF, 1'b0, 32'h0,        1'b1});
    tbl.push_back('{1'b0, 10'd1,    32'h0,        4'hF, 1'b0, 32'hDEADBEEF, 1'b0});

    clear_models();
    reset = 1'b1; pselx = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    set_strb(4'hF);
    step(); step();
    chk("rst_rdy", 32'(pready), 0);
    chk("rst_err", 32'(pslverr), 0);
    chk("rst_rdata", prdata, 0);
    reset = 1'b0;
    step();

    // reset mid-write: previously written data is cleared, pending write lost
    xfer(1'b1, 10'd1, 32'h11111111, 4'hF, 1'b0, rd, er);
    paddr = 10'd1; pwrite = 1'b1; pwdata = 32'hDEADBEEF; pselx = 1'b1; penable = 1'b0;
    step();
    penable = 1'b1;
    step();
    reset = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      chk("rst_mid_rdy", 32'(pready), 0);
      chk("rst_mid_err", 32'(pslverr), 0);
      chk("rst_mid_rdata", prdata, 0);
      chk("rst_mid_rdy0", 32'(pready0), 0);
      if (c == 0) begin pselx = 1'b0; penable = 1'b0; end
      step();
    end
    reset = 1'b0;
    clear_models();
    step();
    xfer(1'b0, 10'd1, 32'h0, 4'hF, 1'b0, rd, er);
    chk("rst_read_addr1", rd, 32'h0);

    // directed table
    foreach (tbl[i]) begin
      xfer(tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].ab, rd, er);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
    end

    // back-to-back: write addr 2, then SETUP for a read straight from ACCESS
    paddr = 10'd2; pwrite = 1'b1; pwdata = 32'h12345678; set_strb(4'hF);
    pselx = 1'b1; penable = 1'b0;
    step();
    penable = 1'b1;
    step();
    chk("b2b_w0_rdy", 32'(pready0), 1);
    m0[2] = 32'h12345678;
    chk("b2b_w1_early", 32'(pready), 0);
    step();
    chk("b2b_w1_rdy", 32'(pready), 1);
    m1[2] = 32'h12345678;
    pwrite = 1'b0; penable = 1'b0;
    step();
    chk("b2b_setup_rdy", 32'(pready), 0);
    chk("b2b_setup_rdy0", 32'(pready0), 0);
    penable = 1'b1;
    step();
    chk("b2b_r0_rdy", 32'(pready0), 1);
    chk("b2b_r0_rdata", prdata0, 32'h12345678);
    chk("b2b_r1_early", 32'(pready), 0);
    step();
    chk("b2b_r1_rdy", 32'(pready), 1);
    chk("b2b_r1_rdata", prdata, 32'h12345678);
    chk("b2b_r1_err", 32'(pslverr), 0);
    pselx = 1'b0; penable = 1'b0;
    step();

`ifdef APB_SLAVE_PSTRB_EN
    xfer(1'b1, 10'd4, 32'hAABBCCDD, 4'hF, 1'b0, rd, er);
    xfer(1'b1, 10'd4, 32'h00001100, 4'b0010, 1'b0, rd, er);
    xfer(1'b0, 10'd4, 32'h0, 4'hF, 1'b0, rd, er);
    chk("strb_rdata", rd, 32'hAABB11DD);
    xfer(1'b1, 10'd4, 32'hFFFFFFFF, 4'h0, 1'b0, rd, er);
    chk("strb0_err", 32'(er), 0);
    xfer(1'b0, 10'd4, 32'h0, 4'hF, 1'b0, rd, er);
    chk("strb0_rdata", rd, 32'hAABB11DD);
`endif

    // randomized transfers against the models
    for (int i = 0; i < 80; i++) begin
      xfer(1'($urandom_range(0, 1)), 10'($urandom_range(0, 19)), $urandom,
           4'($urandom_range(0, 15)), 1'($urandom_range(0, 7) == 0), rd, er);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
